ants_re_framer: RTL and testbench

- Source-side feeder for mac_ants: drives i_ants_data, i_rvalid and i_code_word.
- Takes split I/Q antenna samples from the front end, one RE per valid cycle.
- Repacks each antenna lane into {I[15:0],Q[15:0]}, frames each symbol as NUM_RE REs and counts them.
- Holds a double-buffered code-word bank so the beam weights for a symbol change only on a symbol boundary.

---
 rtl/ants_re_framer.sv | 154 +++++++++++++++
 tb/tb_ants_re_framer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ants_re_framer.sv
// Source-side RE framer for mac_ants: repacks split I/Q lanes, frames symbols of NUM_RE REs
// and presents a double-buffered code-word bank that only swaps on a symbol boundary.
module ants_re_framer #(
  parameter int unsigned ANT    = 32,
  parameter int unsigned IW     = 32,
  parameter int unsigned NUM_RE = 480,
  parameter int unsigned BEAM   = 16
) (
  input  logic                     i_clk,
  input  logic                     reset,
  input  logic [ANT*16-1:0]        i_ant_i,
  input  logic [ANT*16-1:0]        i_ant_q,
  input  logic                     i_valid,
  input  logic                     i_sym_start,
  input  logic [$clog2(BEAM)-1:0]  i_beam_sel,
  input  logic                     i_cw_wen,
  input  logic [$clog2(BEAM)-1:0]  i_cw_beam,
  input  logic [$clog2(ANT)-1:0]   i_cw_ant,
  input  logic [31:0]              i_cw_data,
  input  logic                     i_cw_commit,
  output logic [ANT*IW-1:0]        o_ants_data,
  output logic                     o_rvalid,
  output logic [ANT*IW-1:0]        o_code_word,
  output logic                     o_sop,
  output logic                     o_eop,
  output logic [15:0]              o_re_num,
  output logic                     o_err
);

  localparam logic [15:0] LastRe = 16'(NUM_RE - 1);

  typedef enum logic {StIdle, StRun} state_e;

  state_e                    state_q, state_d;
  logic [15:0]               cnt_q, cnt_d;
  logic [15:0]               re_q, re_d;
  logic                      rvalid_q, sop_q, sop_d, eop_q, eop_d, err_q, err_d;
  logic                      accept, start, commit_now;
  logic [ANT*IW-1:0]         data_q, packed_re;
  logic [ANT*IW-1:0]         shadow_q [BEAM];
  logic [ANT*IW-1:0]         active_q [BEAM];
  logic                      pending_q;
  logic [$clog2(BEAM)-1:0]   beam_lat_q;

  assign start = i_valid & i_sym_start;
  // A symbol start is accepted in either state, so it is also the swap point.
  assign commit_now = start & (pending_q | i_cw_commit);

  always_comb begin
    packed_re = '0;
    for (int j = 0; j < ANT; j++) begin
      packed_re[IW*j +: IW] = {i_ant_i[16*j +: 16], i_ant_q[16*j +: 16]};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    re_d    = re_q;
    accept  = 1'b0;
    sop_d   = 1'b0;
    eop_d   = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          accept = 1'b1;
          sop_d  = 1'b1;
          re_d   = '0;
        end
      end
      StRun: begin
        if (start) begin
          accept = 1'b1;
          sop_d  = 1'b1;
          err_d  = 1'b1;
          re_d   = '0;
        end else if (i_valid) begin
          accept = 1'b1;
          re_d   = cnt_q;
        end
      end
    endcase
    if (accept) begin
      if (re_d == LastRe) begin
        eop_d   = 1'b1;
        state_d = StIdle;
      end else begin
        state_d = StRun;
        cnt_d   = re_d + 16'd1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      re_q     <= '0;
      rvalid_q <= 1'b0;
      sop_q    <= 1'b0;
      eop_q    <= 1'b0;
      err_q    <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      re_q     <= re_d;
      rvalid_q <= accept;
      sop_q    <= sop_d;
      eop_q    <= eop_d;
      err_q    <= err_d;
      if (accept) begin
        data_q <= packed_re;
      end
    end
  end

  // Shadow/active banks; the swap copies the pre-write shadow since all updates are non-blocking.
  always_ff @(posedge i_clk) begin
    if (reset) begin
      for (int b = 0; b < BEAM; b++) begin
        shadow_q[b] <= '0;
        active_q[b] <= '0;
      end
      pending_q  <= 1'b0;
      beam_lat_q <= '0;
    end else begin
      if (i_cw_wen) begin
        shadow_q[i_cw_beam][IW*i_cw_ant +: IW] <= i_cw_data;
      end
      if (start) begin
        beam_lat_q <= i_beam_sel;
      end
      if (commit_now) begin
        for (int b = 0; b < BEAM; b++) begin
          active_q[b] <= shadow_q[b];
        end
        pending_q <= 1'b0;
      end else if (i_cw_commit) begin
        pending_q <= 1'b1;
      end
    end
  end

  assign o_ants_data = data_q;
  assign o_rvalid    = rvalid_q;
  assign o_sop       = sop_q;
  assign o_eop       = eop_q;
  assign o_err       = err_q;
  assign o_re_num    = re_q;
  assign o_code_word = active_q[beam_lat_q];

endmodule

// File: tb/tb_ants_re_framer.sv
// Bench for ants_re_framer: a symbol-level model checked every cycle plus directed literal checks.
module tb_ants_re_framer;

  localparam int ANT    = 32;
  localparam int IW     = 32;
  localparam int NUM_RE = 480;
  localparam int BEAM   = 16;

  logic                    i_clk;
  logic                    reset;
  logic [ANT*16-1:0]       i_ant_i, i_ant_q;
  logic                    i_valid, i_sym_start;
  logic [3:0]              i_beam_sel, i_cw_beam;
  logic [4:0]              i_cw_ant;
  logic [31:0]             i_cw_data;
  logic                    i_cw_wen, i_cw_commit;
  logic [ANT*IW-1:0]       o_ants_data, o_code_word;
  logic                    o_rvalid, o_sop, o_eop, o_err;
  logic [15:0]             o_re_num;

  ants_re_framer #(.ANT(ANT), .IW(IW), .NUM_RE(NUM_RE), .BEAM(BEAM)) dut (
    .i_clk       (i_clk),
    .reset       (reset),
    .i_ant_i     (i_ant_i),
    .i_ant_q     (i_ant_q),
    .i_valid     (i_valid),
    .i_sym_start (i_sym_start),
    .i_beam_sel  (i_beam_sel),
    .i_cw_wen    (i_cw_wen),
    .i_cw_beam   (i_cw_beam),
    .i_cw_ant    (i_cw_ant),
    .i_cw_data   (i_cw_data),
    .i_cw_commit (i_cw_commit),
    .o_ants_data (o_ants_data),
    .o_rvalid    (o_rvalid),
    .o_code_word (o_code_word),
    .o_sop       (o_sop),
    .o_eop       (o_eop),
    .o_re_num    (o_re_num),
    .o_err       (o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_wide(input string name, input logic [ANT*IW-1:0] act,
                          input logic [ANT*IW-1:0] exp);
    int lane;
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      lane = 0;
      for (int j = ANT - 1; j >= 0; j--) if (act[32*j +: 32] !== exp[32*j +: 32]) lane = j;
      $display("FAIL %s lane %0d: got %08h expected %08h (t=%0t)", name, lane,
               act[32*lane +: 32], exp[32*lane +: 32], $time);
    end
  endtask

  // Symbol-level model: tracks whether a symbol is open, the next RE index and both banks.
  logic [31:0]       m_shadow [BEAM][ANT];
  logic [31:0]       m_active [BEAM][ANT];
  bit                m_pending, m_in_sym, m_acc;
  int                m_beam_lat, m_next_re, m_re;
  bit                exp_rvalid, exp_sop, exp_eop, exp_err;
  int                exp_re;
  logic [ANT*IW-1:0] exp_data, exp_cw;

  always @(posedge i_clk) begin
    if (reset) begin
      for (int b = 0; b < BEAM; b++)
        for (int a = 0; a < ANT; a++) begin
          m_shadow[b][a] = '0;
          m_active[b][a] = '0;
        end
      m_pending = 0; m_in_sym = 0; m_beam_lat = 0; m_next_re = 0;
      exp_rvalid = 0; exp_sop = 0; exp_eop = 0; exp_err = 0; exp_re = 0; exp_data = '0;
    end else begin
      exp_rvalid = 0; exp_sop = 0; exp_eop = 0; exp_err = 0;
      m_pending = m_pending | i_cw_commit;
      m_acc = 0;
      if (i_valid && i_sym_start) begin
        m_acc = 1; m_re = 0; exp_sop = 1; exp_err = m_in_sym;
        if (m_pending) begin
          m_active = m_shadow;
          m_pending = 0;
        end
        m_beam_lat = int'(i_beam_sel);
      end else if (i_valid && m_in_sym) begin
        m_acc = 1; m_re = m_next_re;
      end
      if (i_cw_wen) m_shadow[i_cw_beam][i_cw_ant] = i_cw_data;
      if (m_acc) begin
        exp_rvalid = 1;
        exp_re = m_re;
        for (int j = 0; j < ANT; j++) exp_data[32*j +: 32] = {i_ant_i[16*j +: 16], i_ant_q[16*j +: 16]};
        exp_eop = (m_re == NUM_RE - 1);
        m_in_sym = !exp_eop;
        m_next_re = m_re + 1;
      end
    end
  end

  bit chk_en = 0;
  int cnt_rvalid = 0, cnt_sop = 0, cnt_eop = 0, cnt_err = 0;

  always @(negedge i_clk) begin
    if (chk_en) begin
      for (int a = 0; a < ANT; a++) exp_cw[32*a +: 32] = m_active[m_beam_lat][a];
      chk("rvalid", o_rvalid, exp_rvalid);
      chk("sop", o_sop, exp_sop);
      chk("eop", o_eop, exp_eop);
      chk("err", o_err, exp_err);
      if (exp_rvalid) chk("re_num", o_re_num, exp_re);
      chk_wide("ants_data", o_ants_data, exp_data);
      chk_wide("code_word", o_code_word, exp_cw);
      cnt_rvalid += int'(o_rvalid);
      cnt_sop    += int'(o_sop);
      cnt_eop    += int'(o_eop);
      cnt_err    += int'(o_err);
    end
  end

  task automatic set_lanes_ij();
    for (int j = 0; j < ANT; j++) begin
      i_ant_i[16*j +: 16] = 16'(j);
      i_ant_q[16*j +: 16] = 16'(-j);
    end
  endtask

  task automatic set_lanes_rand();
    for (int j = 0; j < ANT; j++) begin
      i_ant_i[16*j +: 16] = 16'($urandom);
      i_ant_q[16*j +: 16] = 16'($urandom);
    end
  endtask

  // Drives one cycle; on return the DUT outputs reflect that cycle's input.
  task automatic re_cycle(input bit v, input bit s);
    i_valid = v;
    i_sym_start = s;
    @(negedge i_clk);
    #1;
    i_valid = 0; i_sym_start = 0; i_cw_wen = 0; i_cw_commit = 0;
  endtask

  task automatic cw_write(input int beam, input int ant, input logic [31:0] data);
    i_cw_wen = 1; i_cw_beam = 4'(beam); i_cw_ant = 5'(ant); i_cw_data = data;
  endtask

  int e0, s0, v0, r0, c;

  initial begin
    reset = 1; i_ant_i = '0; i_ant_q = '0; i_valid = 0; i_sym_start = 0; i_beam_sel = '0;
    i_cw_wen = 0; i_cw_beam = '0; i_cw_ant = '0; i_cw_data = '0; i_cw_commit = 0;
    @(posedge i_clk);
    #1 chk_en = 1;
    repeat (2) @(negedge i_clk);
    #1;
    chk("reset_rvalid", o_rvalid, 0);
    chk("reset_re_num", o_re_num, 0);
    chk_wide("reset_code_word", o_code_word, '0);
    reset = 0;

    // 1: full symbol, lane j I=j Q=-j
    set_lanes_ij();
    e0 = cnt_eop; r0 = cnt_err;
    for (int r = 0; r < NUM_RE; r++) begin
      re_cycle(1, r == 0);
      if (r == 0) begin
        chk("t1_rvalid", o_rvalid, 1);
        chk("t1_sop", o_sop, 1);
        chk("t1_re0", o_re_num, 0);
        chk("t1_lane5", o_ants_data[5*32 +: 32], 32'h0005FFFB);
      end
      if (r == NUM_RE - 1) begin
        chk("t1_eop", o_eop, 1);
        chk("t1_re_last", o_re_num, 479);
      end
    end
    chk("t1_eop_count", cnt_eop - e0, 1);
    chk("t1_err_count", cnt_err - r0, 0);
    re_cycle(0, 0);

    // 2: valid dropped every 3rd cycle
    e0 = cnt_eop; v0 = cnt_rvalid;
    c = 0;
    for (int r = 0; r < NUM_RE; c++) begin
      set_lanes_rand();
      if (c % 3 != 2) begin
        re_cycle(1, r == 0);
        r++;
      end else begin
        re_cycle(0, 0);
      end
    end
    chk("t2_re_last", o_re_num, 479);
    chk("t2_rvalid_count", cnt_rvalid - v0, 480);
    chk("t2_eop_count", cnt_eop - e0, 1);
    re_cycle(0, 0);

    // 3: short symbol aborted at RE 100
    e0 = cnt_eop; r0 = cnt_err;
    for (int r = 0; r < 100; r++) begin
      set_lanes_rand();
      re_cycle(1, r == 0);
    end
    re_cycle(1, 1);
    chk("t3_err", o_err, 1);
    chk("t3_sop", o_sop, 1);
    chk("t3_re0", o_re_num, 0);
    re_cycle(1, 0);
    chk("t3_err_clear", o_err, 0);
    chk("t3_re1", o_re_num, 1);
    for (int r = 2; r < NUM_RE; r++) re_cycle(1, 0);
    chk("t3_eop_count", cnt_eop - e0, 1);
    chk("t3_err_count", cnt_err - r0, 1);

    // 4: code-word commit, mid-symbol write, same-cycle write+commit+sop
    cw_write(3, 0, 32'h7FFF0000);
    re_cycle(0, 0);
    i_cw_commit = 1;
    re_cycle(0, 0);
    chk("t4_cw_before", o_code_word[31:0], 0);
    i_beam_sel = 4'd3;
    re_cycle(1, 1);
    chk("t4_cw_at_sop", o_code_word[31:0], 32'h7FFF0000);
    for (int r = 1; r < NUM_RE; r++) begin
      if (r == 10) cw_write(3, 0, 32'h12345678);
      re_cycle(1, 0);
      if (r == 20) chk("t4_cw_hold", o_code_word[31:0], 32'h7FFF0000);
    end
    cw_write(3, 0, 32'hAAAA5555);
    i_cw_commit = 1;
    re_cycle(1, 1);
    chk("t4_cw_prewrite", o_code_word[31:0], 32'h12345678);
    for (int r = 1; r < NUM_RE; r++) re_cycle(1, 0);

    // 5: back-to-back symbols, then valids while idle
    r0 = cnt_err;
    i_cw_commit = 1;
    re_cycle(1, 1);
    chk("t5_cw_commit", o_code_word[31:0], 32'hAAAA5555);
    for (int r = 1; r < NUM_RE; r++) re_cycle(1, 0);
    chk("t5_eop_a", o_eop, 1);
    re_cycle(1, 1);
    chk("t5_sop_b", o_sop, 1);
    chk("t5_err_b", o_err, 0);
    for (int r = 1; r < NUM_RE; r++) re_cycle(1, 0);
    v0 = cnt_rvalid;
    for (int r = 0; r < 5; r++) begin
      set_lanes_rand();
      re_cycle(1, 0);
    end
    chk("t5_idle_rvalid", cnt_rvalid - v0, 0);
    chk("t5_err_count", cnt_err - r0, 0);

    // 6: reset mid-symbol
    for (int r = 0; r < 200; r++) re_cycle(1, r == 0);
    reset = 1;
    re_cycle(1, 0);
    reset = 0;
    chk("t6_rvalid", o_rvalid, 0);
    chk("t6_sop", o_sop, 0);
    chk("t6_eop", o_eop, 0);
    chk("t6_err", o_err, 0);
    chk("t6_re_num", o_re_num, 0);
    chk_wide("t6_ants_data", o_ants_data, '0);
    chk_wide("t6_code_word", o_code_word, '0);
    set_lanes_rand();
    re_cycle(1, 1);
    chk("t6_restart_sop", o_sop, 1);
    chk("t6_restart_re0", o_re_num, 0);
    chk("t6_restart_err", o_err, 0);
    for (int r = 1; r < 5; r++) re_cycle(1, 0);
    chk("t6_re4", o_re_num, 4);
    re_cycle(0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
